mem_access_unit: RTL and testbench

//  MEM-stage load/store unit of the pipelined core. Sits between the pipeline and the 4-lane byte-enabled data memory.

---
 rtl/mem_access_unit_pkg.sv | 37 +++
 rtl/mem_access_unit_load_align.sv | 30 +++
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 codes,
// FSM states and access-size decode.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC0 = 3'd1,
        ACC1 = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

    // Access size in bytes; only meaningful for legal funct3 values.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Stores have no unsigned variants.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load alignment: shifts the addressed bytes down to bit 0
// (spanning two words for split accesses) and sign/zero-extends them.
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic        split,
    output logic [31:0] result
);

    logic [5:0]  shamt;
    logic [31:0] sh;

    always_comb begin
        shamt  = {1'b0, off, 3'b000};
        sh     = split ? 32'({hi, lo} >> shamt) : (lo >> shamt);
        result = sh;
        case (funct3)
            F3_B:    result = {{24{sh[7]}}, sh[7:0]};
            F3_H:    result = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   result = {24'b0, sh[7:0]};
            F3_HU:   result = {16'b0, sh[15:0]};
            default: result = sh;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one outstanding byte-addressed request, split
// into one or two word beats against a 1-cycle-latency byte-lane memory.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [3:0]            mem_byte_sel,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    state_t state, nxt;

    // Request decode, evaluated only when the request is accepted.
    logic [1:0]            off;
    logic [ADDR_WIDTH-1:0] word;
    logic [2:0]            size;
    logic                  split;
    logic                  req_fault;
    logic [7:0]            base_mask, lane_mask;
    logic [5:0]            wshamt;
    logic [31:0]           wrot;

    always_comb begin
        off       = req_addr[1:0];
        word      = req_addr[ADDR_WIDTH+1:2];
        size      = f3_size(req_funct3);
        split     = ({1'b0, off} + size) > 3'd4;
        req_fault = (req_addr[31:ADDR_WIDTH+2] != '0) || !f3_legal(req_funct3, req_we)
                    || (split && (&word));
        case (size)
            3'd1:    base_mask = 8'h01;
            3'd2:    base_mask = 8'h03;
            default: base_mask = 8'h0F;
        endcase
        lane_mask = base_mask << off;
        wshamt    = {1'b0, off, 3'b000};
        wrot      = (req_wdata << wshamt) | (req_wdata >> (6'd32 - wshamt));
    end

    // Registered copy of the accepted request.
    logic                  r_we;
    logic [2:0]            r_f3;
    logic [1:0]            r_off;
    logic [ADDR_WIDTH-1:0] r_word;
    logic                  r_split;
    logic [7:0]            r_mask;
    logic [31:0]           r_wdata;
    logic [31:0]           lo_buf;
    logic [31:0]           load_res;
    logic [31:0]           align_lo;

    assign align_lo = r_split ? lo_buf : mem_rdata;

    mem_load_align u_align (
        .lo     (align_lo),
        .hi     (mem_rdata),
        .off    (r_off),
        .funct3 (r_f3),
        .split  (r_split),
        .result (load_res)
    );

    always_comb begin
        nxt          = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_byte_sel = 4'b0;
        mem_addr     = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) nxt = req_fault ? RESP : ACC0;
            end
            ACC0: begin
                mem_we       = r_we;
                mem_re       = !r_we;
                mem_byte_sel = r_mask[3:0];
                mem_addr     = r_word;
                nxt          = r_split ? ACC1 : (r_we ? RESP : WAIT);
            end
            ACC1: begin
                mem_we       = r_we;
                mem_re       = !r_we;
                mem_byte_sel = r_mask[7:4];
                mem_addr     = r_word + ADDR_WIDTH'(1);
                nxt          = r_we ? RESP : WAIT;
            end
            WAIT: nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            r_we       <= 1'b0;
            r_f3       <= 3'b0;
            r_off      <= 2'b0;
            r_word     <= '0;
            r_split    <= 1'b0;
            r_mask     <= 8'b0;
            r_wdata    <= 32'b0;
            lo_buf     <= 32'b0;
            resp_rdata <= 32'b0;
            resp_fault <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_off   <= off;
                r_word  <= word;
                r_split <= split;
                r_mask  <= lane_mask;
                r_wdata <= wrot;
            end
            // Beat0 read data arrives during ACC1; hold it for the merge.
            if (state == ACC1 && !r_we) lo_buf <= mem_rdata;
            // Response payload is latched once on entry to RESP and held.
            if (nxt == RESP && state != RESP) begin
                resp_fault <= (state == IDLE);
                resp_rdata <= (state == WAIT) ? load_res : 32'b0;
            end
        end
    end

    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a 1-cycle-latency byte-lane RAM model.
module tb_mem_access_unit;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic [8:0]  mem_addr;
    logic        mem_we, mem_re;
    logic [3:0]  mem_byte_sel;
    logic [31:0] mem_wdata, mem_rdata;

    mem_access_unit #(.ADDR_WIDTH(9)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_byte_sel(mem_byte_sel), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: byte-lane writes, registered reads.
    logic [31:0] ram [512];
    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_byte_sel[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Observations from the last request.
    int          lat, nbeats, stray;
    logic [31:0] rd;
    logic        flt;
    logic [8:0]  b_addr [2];
    logic [3:0]  b_sel  [2];
    logic [31:0] b_wdata[2];
    logic        b_we   [2];

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        // Scramble request fields after the handshake; the unit must ignore them.
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b011;
        req_addr = 32'hFFFF_FFFF; req_wdata = ~wd;
        lat = 1; nbeats = 0; stray = 0;
        while (!resp_valid && lat < 20) begin
            if (mem_we || mem_re) begin
                if (nbeats < 2) begin
                    b_addr[nbeats] = mem_addr; b_sel[nbeats] = mem_byte_sel;
                    b_wdata[nbeats] = mem_wdata; b_we[nbeats] = mem_we;
                end
                nbeats++;
            end else if (mem_byte_sel != 4'b0) stray++;
            @(posedge clk); #1;
            lat++;
        end
        if (resp_valid && (mem_we || mem_re || mem_byte_sel != 4'b0)) stray++;
        rd = resp_rdata; flt = resp_fault;
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if ({req_ready, resp_valid, resp_fault} !== 3'b100) begin n_fail++;
            $display("FAIL reset_hs: got %b want 100", {req_ready, resp_valid, resp_fault}); end
        n_checks++; if ({mem_we, mem_re, mem_byte_sel} !== 6'b0) begin n_fail++;
            $display("FAIL reset_mem: got %b want 000000", {mem_we, mem_re, mem_byte_sel}); end
        n_checks++; if (mem_addr !== 9'd0 || resp_rdata !== 32'd0) begin n_fail++;
            $display("FAIL reset_data: addr %h rdata %h want 0 0", mem_addr, resp_rdata); end
    endtask

    task automatic test_aligned();
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        n_checks++; if (lat !== 2 || flt !== 1'b0) begin n_fail++;
            $display("FAIL sw_lat: got lat %0d fault %b want 2 0", lat, flt); end
        n_checks++; if (nbeats !== 1 || b_addr[0] !== 9'd4 || b_sel[0] !== 4'hF || b_we[0] !== 1'b1
                        || b_wdata[0] !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL sw_beat: n %0d addr %0d sel %b we %b wd %h want 1 4 1111 1 deadbeef",
                     nbeats, b_addr[0], b_sel[0], b_we[0], b_wdata[0]); end
        ack();
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        n_checks++; if (lat !== 3 || rd !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL lw: got lat %0d data %h want 3 deadbeef", lat, rd); end
        n_checks++; if (nbeats !== 1 || b_addr[0] !== 9'd4 || b_sel[0] !== 4'hF || b_we[0] !== 1'b0
                        || stray !== 0) begin n_fail++;
            $display("FAIL lw_beat: n %0d addr %0d sel %b we %b stray %0d want 1 4 1111 0 0",
                     nbeats, b_addr[0], b_sel[0], b_we[0], stray); end
        ack();
    endtask

    task automatic test_byte();
        issue(1'b1, 3'b000, 32'h13, 32'h0000_0080);
        n_checks++; if (b_sel[0] !== 4'b1000 || b_wdata[0][31:24] !== 8'h80 || b_addr[0] !== 9'd4)
            begin n_fail++;
            $display("FAIL sb_beat: sel %b wd %h addr %0d want 1000 80xxxxxx 4",
                     b_sel[0], b_wdata[0], b_addr[0]); end
        ack();
        issue(1'b0, 3'b000, 32'h13, 32'h0);
        n_checks++; if (rd !== 32'hFFFF_FF80) begin n_fail++;
            $display("FAIL lb: got %h want ffffff80", rd); end
        ack();
        issue(1'b0, 3'b100, 32'h13, 32'h0);
        n_checks++; if (rd !== 32'h0000_0080) begin n_fail++;
            $display("FAIL lbu: got %h want 00000080", rd); end
        ack();
    endtask

    task automatic test_split();
        issue(1'b1, 3'b010, 32'h0E, 32'h1122_3344);
        n_checks++; if (lat !== 3 || nbeats !== 2) begin n_fail++;
            $display("FAIL ssw_lat: got lat %0d beats %0d want 3 2", lat, nbeats); end
        n_checks++; if (b_addr[0] !== 9'd3 || b_sel[0] !== 4'b1100 || b_addr[1] !== 9'd4
                        || b_sel[1] !== 4'b0011 || b_wdata[0] !== 32'h3344_1122) begin n_fail++;
            $display("FAIL ssw_beats: %0d/%b %0d/%b wd %h want 3/1100 4/0011 33441122",
                     b_addr[0], b_sel[0], b_addr[1], b_sel[1], b_wdata[0]); end
        ack();
        issue(1'b0, 3'b010, 32'h0E, 32'h0);
        n_checks++; if (lat !== 4 || rd !== 32'h1122_3344 || nbeats !== 2) begin n_fail++;
            $display("FAIL slw: got lat %0d data %h beats %0d want 4 11223344 2", lat, rd, nbeats); end
        ack();
        issue(1'b0, 3'b001, 32'h0F, 32'h0);
        n_checks++; if (lat !== 4 || rd !== 32'h0000_2233) begin n_fail++;
            $display("FAIL slh: got lat %0d data %h want 4 00002233", lat, rd); end
        ack();
    endtask

    task automatic test_faults();
        logic [31:0] fa [4] = '{32'h800, 32'h7FF, 32'h10, 32'h10};
        logic [2:0]  ff [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        logic        fw [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            issue(fw[i], ff[i], fa[i], 32'h5555_AAAA);
            n_checks++; if (lat !== 1 || flt !== 1'b1 || rd !== 32'd0 || nbeats !== 0 || stray !== 0)
                begin n_fail++;
                $display("FAIL fault%0d: lat %0d fault %b data %h beats %0d want 1 1 0 0",
                         i, lat, flt, rd, nbeats); end
            ack();
        end
    endtask

    task automatic test_backpressure();
        issue(1'b0, 3'b001, 32'h12, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_80AD || req_ready !== 1'b0)
                begin n_fail++;
                $display("FAIL bp_hold%0d: valid %b data %h ready %b want 1 ffff80ad 0",
                         c, resp_valid, resp_rdata, req_ready); end
        end
        ack();
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++;
            $display("FAIL bp_release: valid %b ready %b want 0 1", resp_valid, req_ready); end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 3'b101, 32'h12, 32'h0);
        n_checks++; if (rd !== 32'h0000_80AD) begin n_fail++;
            $display("FAIL lhu: got %h want 000080ad", rd); end
        ack();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++;
            $display("FAIL b2b_idle: ready %b want 1", req_ready); end
        issue(1'b0, 3'b100, 32'h11, 32'h0);
        n_checks++; if (rd !== 32'h0000_0011 || lat !== 3) begin n_fail++;
            $display("FAIL b2b_lbu: got %h lat %0d want 00000011 3", rd, lat); end
        ack();
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h22; req_wdata = 32'hAABB_CCDD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== 9'd8 || mem_byte_sel !== 4'b1100) begin n_fail++;
            $display("FAIL rm_acc0: we %b addr %0d sel %b want 1 8 1100", mem_we, mem_addr, mem_byte_sel); end
        @(posedge clk); #1;
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== 9'd9 || mem_byte_sel !== 4'b0011) begin n_fail++;
            $display("FAIL rm_acc1: we %b addr %0d sel %b want 1 9 0011", mem_we, mem_addr, mem_byte_sel); end
        rst = 1'b1;
        #1;
        n_checks++; if ({mem_we, mem_re, mem_byte_sel, req_ready, resp_valid} !== 8'b0000_0010
                        || mem_addr !== 9'd0) begin n_fail++;
            $display("FAIL rm_async: flags %b addr %0d want 00000010 0",
                     {mem_we, mem_re, mem_byte_sel, req_ready, resp_valid}, mem_addr); end
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (ram[8] !== 32'hCCDD_0000 || ram[9] !== 32'h0) begin n_fail++;
            $display("FAIL rm_ram: w8 %h w9 %h want ccdd0000 00000000", ram[8], ram[9]); end
        issue(1'b0, 3'b010, 32'h20, 32'h0);
        n_checks++; if (rd !== 32'hCCDD_0000 || lat !== 3 || flt !== 1'b0) begin n_fail++;
            $display("FAIL rm_next: data %h lat %0d fault %b want ccdd0000 3 0", rd, lat, flt); end
        ack();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        #1;
        test_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        test_aligned();
        test_byte();
        test_split();
        test_faults();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
